// File: rtl/fmul_rr_sched.sv
// Round-robin scheduler sharing one external combinational double multiplier among
// NUM_REQ requesters; one operation in flight, result tagged with the requester id.
module fmul_rr_sched #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int MUL_CYCLES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  output logic [DATA_WIDTH-1:0]         fmul_a_o,
  output logic [DATA_WIDTH-1:0]         fmul_b_o,
  input  logic [DATA_WIDTH-1:0]         fmul_c_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic [DATA_WIDTH-1:0]         resp_c_o,
  output logic [ID_W-1:0]               resp_id_o,
  output logic                          busy_o
);
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int IW1   = ID_W + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d, id_q, id_d, resp_id_q, resp_id_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [ID_W-1:0]       win;
  logic [IW1-1:0]        idx;
  logic                  found, accept;

  // Rotating-priority search: first valid slot at ptr, ptr+1, ... (mod NUM_REQ).
  // ptr and i are both < NUM_REQ, so one conditional subtract wraps the sum.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_q} + IW1'(i);
      if (idx >= IW1'(NUM_REQ)) idx = idx - IW1'(NUM_REQ);
      if (!found && req_valid_i[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  assign accept      = (state_q == IDLE) && found && !rst_i;
  assign req_ready_o = accept ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    resp_id_d = resp_id_q;
    case (state_q)
      IDLE: if (accept) begin
        a_d     = req_a_i[win*DATA_WIDTH +: DATA_WIDTH];
        b_d     = req_b_i[win*DATA_WIDTH +: DATA_WIDTH];
        id_d    = win;
        ptr_d   = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      // The multiplier path is only trusted once the settle count has expired.
      WAIT: if (cnt_q == '0) begin
        c_d       = fmul_c_i;
        resp_id_d = id_q;
        state_d   = RESP;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESP: if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      resp_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      resp_id_q <= resp_id_d;
    end
  end

  assign fmul_a_o     = a_q;
  assign fmul_b_o     = b_q;
  assign resp_c_o     = c_q;
  assign resp_id_o    = resp_id_q;
  assign resp_valid_o = (state_q == RESP);
  assign busy_o       = (state_q != IDLE);
endmodule
